// File: rtl/axis_byte_arbiter_if.sv
// Byte-stream bundle between the serialisers, the arbiter and the shared async-FIFO write port.
interface axis_byte_arbiter_if #(
  parameter int NUM_SRC = 4
);
  localparam int GW = $clog2(NUM_SRC);

  logic [NUM_SRC*8-1:0] s_byte_data;
  logic [NUM_SRC-1:0]   s_byte_valid;
  logic [NUM_SRC-1:0]   s_byte_last;
  logic [NUM_SRC-1:0]   s_byte_ready;
  logic [7:0]           o_to_fifo;
  logic                 w_req;
  logic                 w_full;
  logic [GW-1:0]        o_grant_id;
  logic                 o_busy;

  modport master (
    input  s_byte_data, s_byte_valid, s_byte_last, w_full,
    output s_byte_ready, o_to_fifo, w_req, o_grant_id, o_busy
  );

  modport slave (
    output s_byte_data, s_byte_valid, s_byte_last, w_full,
    input  s_byte_ready, o_to_fifo, w_req, o_grant_id, o_busy
  );
endinterface

// File: rtl/axis_byte_arbiter.sv
// Round-robin, packet-locked arbiter sharing one byte-wide FIFO write port among NUM_SRC streams.
// Optional ARB_BURST_LIMIT_EN also releases a grant after MAX_BURST bytes.
module axis_byte_arbiter_lane (
  input  logic       sel_i,
  input  logic       w_full_i,
  input  logic       valid_i,
  input  logic       last_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       wr_o,
  output logic       last_o,
  output logic [7:0] data_o
);
  assign ready_o = sel_i & ~w_full_i;
  assign wr_o    = ready_o & valid_i;
  assign last_o  = sel_i & last_i;
  assign data_o  = sel_i ? data_i : 8'h00;
endmodule

module axis_byte_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                m_axis_aclk,
  input  logic                m_axis_reset_n,
  axis_byte_arbiter_if.master bus
);
  localparam int GW = $clog2(NUM_SRC);

  if (NUM_SRC < 2 || NUM_SRC > 16 || MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_cfg
    $error("axis_byte_arbiter: NUM_SRC or MAX_BURST out of range");
  end

  typedef enum logic {IDLE, GRANT} state_e;

  state_e             state_q, state_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [GW-1:0]      last_grant_q, last_grant_d;
  logic [GW-1:0]      pick;
  logic [GW:0]        sum;
  logic               any_req;
  logic [NUM_SRC-1:0] sel, lane_ready, lane_wr, lane_last;
  logic [NUM_SRC-1:0][7:0] lane_data;
  logic [7:0]         fifo_byte;
  logic               xfer, xfer_last, release_grant;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
    assign sel[i] = (state_q == GRANT) && (grant_q == GW'(i));
    axis_byte_arbiter_lane u_lane (
      .sel_i    (sel[i]),
      .w_full_i (bus.w_full),
      .valid_i  (bus.s_byte_valid[i]),
      .last_i   (bus.s_byte_last[i]),
      .data_i   (bus.s_byte_data[i*8 +: 8]),
      .ready_o  (lane_ready[i]),
      .wr_o     (lane_wr[i]),
      .last_o   (lane_last[i]),
      .data_o   (lane_data[i])
    );
  end

  // Only the granted lane is non-zero, so an OR merge acts as the output mux.
  always_comb begin
    fifo_byte = '0;
    xfer      = 1'b0;
    xfer_last = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      fifo_byte = fifo_byte | lane_data[i];
      xfer      = xfer | lane_wr[i];
      xfer_last = xfer_last | (lane_wr[i] & lane_last[i]);
    end
  end

  // Descending scan so the closest valid index after last_grant wins.
  always_comb begin
    pick    = last_grant_q;
    any_req = 1'b0;
    sum     = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      sum = {1'b0, last_grant_q} + (GW+1)'(k);
      if (sum >= (GW+1)'(NUM_SRC)) sum = sum - (GW+1)'(NUM_SRC);
      if (bus.s_byte_valid[sum[GW-1:0]]) begin
        pick    = sum[GW-1:0];
        any_req = 1'b1;
      end
    end
  end

`ifdef ARB_BURST_LIMIT_EN
  logic [7:0] burst_q, burst_d;
  logic       burst_hit;

  assign burst_hit     = (burst_q + 8'd1) == 8'(MAX_BURST);
  assign release_grant = xfer_last | (xfer & burst_hit);

  always_comb begin
    burst_d = burst_q;
    if (state_q == IDLE && any_req) burst_d = '0;
    else if (state_q == GRANT && xfer) burst_d = burst_q + 8'd1;
  end

  always_ff @(posedge m_axis_aclk or negedge m_axis_reset_n) begin
    if (!m_axis_reset_n) burst_q <= '0;
    else                 burst_q <= burst_d;
  end
`else
  assign release_grant = xfer_last;
`endif

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d      = GRANT;
          grant_d      = pick;
          last_grant_d = pick;
        end
      end
      GRANT: begin
        if (release_grant) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge m_axis_aclk or negedge m_axis_reset_n) begin
    if (!m_axis_reset_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_SRC-1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.s_byte_ready = lane_ready;
  assign bus.o_to_fifo    = fifo_byte;
  assign bus.w_req        = xfer;
  assign bus.o_grant_id   = grant_q;
  assign bus.o_busy       = (state_q == GRANT);
endmodule

// File: tb/tb_axis_byte_arbiter.sv
// Scoreboard bench: packet-level reference model feeds an expected queue, a monitor pops on w_req.
module tb_axis_byte_arbiter;
  localparam int N    = 4;
  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  axis_byte_arbiter_if #(.NUM_SRC(N)) bus();

  axis_byte_arbiter #(.NUM_SRC(N), .MAX_BURST(MAXB)) dut (
    .m_axis_aclk    (clk),
    .m_axis_reset_n (rst_n),
    .bus            (bus)
  );

  typedef struct { int gid; int data; } exp_t;
  typedef struct { int gid; int data; int cyc; } wr_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int full_pct = 0;
  int gap_pct = 0;

  logic [8:0] src_q [N][$];   // {last, data} per pending byte
  bit         gap_sched [N][$];
  bit         full_sched [$];
  exp_t       exp_q [$];
  wr_t        wlog [$];

  // reference model state and this cycle's expected outputs
  bit             m_busy;
  int             m_gid, m_lg, m_cnt;
  bit             e_busy, e_wreq;
  int             e_gid;
  logic [N-1:0]   e_ready;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: round-robin pick in IDLE, one byte per non-full valid cycle in GRANT.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_gid = 0; m_lg = N-1; m_cnt = 0;
      e_busy = 0; e_gid = 0; e_ready = '0; e_wreq = 0;
      exp_q.delete();
    end else begin
      e_busy = m_busy; e_gid = m_gid; e_ready = '0; e_wreq = 0;
      if (!m_busy) begin
        for (int k = 1; k <= N; k++) begin
          if (!m_busy && bus.s_byte_valid[(m_lg+k)%N]) begin
            m_busy = 1; m_gid = (m_lg+k)%N; m_lg = m_gid; m_cnt = 0;
          end
        end
      end else begin
        if (!bus.w_full) e_ready[m_gid] = 1'b1;
        if (bus.s_byte_valid[m_gid] && !bus.w_full && src_q[m_gid].size() != 0) begin
          e_wreq = 1;
          exp_q.push_back('{m_gid, int'(src_q[m_gid][0][7:0])});
          m_cnt++;
          if (src_q[m_gid][0][8]) m_busy = 0;
`ifdef ARB_BURST_LIMIT_EN
          if (m_cnt == MAXB) m_busy = 0;
`endif
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    #1;
    if (rst_n) begin
      chk("busy", int'(bus.o_busy), int'(e_busy));
      chk("grant_id", int'(bus.o_grant_id), e_gid);
      chk("ready", int'(bus.s_byte_ready), int'(e_ready));
      chk("w_req", int'(bus.w_req), int'(e_wreq));
      if (!e_busy) chk("idle_fifo_data", int'(bus.o_to_fifo), 0);
      if (bus.w_req) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL fifo_write unexpected byte 0x%0h from src %0d", bus.o_to_fifo, bus.o_grant_id);
        end else begin
          e = exp_q.pop_front();
          chk("fifo_data", int'(bus.o_to_fifo), e.data);
          chk("fifo_src", int'(bus.o_grant_id), e.gid);
        end
        wlog.push_back('{int'(bus.o_grant_id), int'(bus.o_to_fifo), cyc});
      end
    end
  end

  task automatic drive();
    bit g;
    bus.w_full = (full_sched.size() != 0) ? full_sched.pop_front() : bit'($urandom_range(99) < full_pct);
    for (int i = 0; i < N; i++) begin
      g = (gap_sched[i].size() != 0) ? gap_sched[i].pop_front() : bit'($urandom_range(99) < gap_pct);
      if (src_q[i].size() != 0) begin
        bus.s_byte_valid[i]      = !g;
        bus.s_byte_data[i*8 +: 8] = src_q[i][0][7:0];
        bus.s_byte_last[i]       = src_q[i][0][8];
      end else begin
        bus.s_byte_valid[i]      = 1'b0;
        bus.s_byte_data[i*8 +: 8] = 8'($urandom);
        bus.s_byte_last[i]       = 1'($urandom);
      end
    end
  endtask

  task automatic step();
    logic [N-1:0] acc;
    @(negedge clk);
    acc = bus.s_byte_valid & bus.s_byte_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (acc[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
    drive();
  endtask

  function automatic bit drained();
    drained = (exp_q.size() == 0) && !bus.o_busy;
    for (int i = 0; i < N; i++) if (src_q[i].size() != 0) drained = 0;
  endfunction

  task automatic run(input string name, input int maxc);
    int n = 0;
    while (!drained() && n < maxc) begin step(); n++; end
    chk({name, "_completed_in_budget"}, int'(n < maxc), 1);
    step(); step();
  endtask

  task automatic add_pkt(input int src, input int len, input int base);
    for (int j = 0; j < len; j++) src_q[src].push_back({(j == len-1), 8'(base + j)});
  endtask

  task automatic chk_log(input string name, input int lb, input int eg[$], input int ed[$]);
    chk({name, "_count"}, wlog.size() - lb, eg.size());
    for (int j = 0; j < eg.size() && lb + j < wlog.size(); j++) begin
      chk({name, "_src"}, wlog[lb+j].gid, eg[j]);
      chk({name, "_data"}, wlog[lb+j].data, ed[j]);
    end
  endtask

  // Called at posedge+3; returns at posedge+3 with reset released.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_busy", int'(bus.o_busy), 0);
    chk("rst_ready", int'(bus.s_byte_ready), 0);
    chk("rst_w_req", int'(bus.w_req), 0);
    chk("rst_fifo_data", int'(bus.o_to_fifo), 0);
    chk("rst_grant_id", int'(bus.o_grant_id), 0);
    for (int i = 0; i < N; i++) begin src_q[i].delete(); gap_sched[i].delete(); end
    full_sched.delete();
    drive();
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lb, t0;
    int eg[$];
    int ed[$];
    bus.s_byte_valid = '0; bus.s_byte_last = '0; bus.s_byte_data = '0; bus.w_full = 1'b0;
    drive();
    #2;
    do_reset();

    // single 3-byte packet from source 1: one bubble then three back-to-back writes
    lb = wlog.size(); t0 = cyc;
    add_pkt(1, 3, 'hA1); drive();
    run("s1", 50);
    eg = '{1, 1, 1}; ed = '{'hA1, 'hA2, 'hA3};
    chk_log("s1", lb, eg, ed);
    for (int j = 0; j < 3 && lb + j < wlog.size(); j++) chk("s1_write_cycle", wlog[lb+j].cyc, t0 + 1 + j);
    chk("s1_busy_after", int'(bus.o_busy), 0);

    // simultaneous requests from reset are served 0,1,2
    step(); step(); @(posedge clk); #2;
    do_reset();
    lb = wlog.size();
    add_pkt(0, 2, 'h00); add_pkt(1, 2, 'h10); add_pkt(2, 2, 'h20); drive();
    run("s2", 100);
    eg = '{0, 0, 1, 1, 2, 2}; ed = '{'h00, 'h01, 'h10, 'h11, 'h20, 'h21};
    chk_log("s2", lb, eg, ed);
    chk("s2_last_grant", int'(bus.o_grant_id), 2);

    // FIFO full for 4 cycles mid-packet: byte held, nothing lost or duplicated
    lb = wlog.size(); t0 = cyc;
    add_pkt(3, 5, 'h30);
    full_sched = '{0, 0, 0, 1, 1, 1, 1};
    drive();
    run("s3", 100);
    eg = '{3, 3, 3, 3, 3}; ed = '{'h30, 'h31, 'h32, 'h33, 'h34};
    chk_log("s3", lb, eg, ed);
    if (wlog.size() >= lb + 3) chk("s3_resume_cycle", wlog[lb+2].cyc, t0 + 7);

    // granted source 2 stalls 5 cycles; source 0 waits for its last byte
    lb = wlog.size(); t0 = cyc;
    add_pkt(2, 4, 'h40); add_pkt(0, 2, 'h50);
    gap_sched[0] = '{1, 1};
    gap_sched[2] = '{0, 0, 0, 1, 1, 1, 1, 1};
    drive();
    run("s4", 100);
    eg = '{2, 2, 2, 2, 0, 0}; ed = '{'h40, 'h41, 'h42, 'h43, 'h50, 'h51};
    chk_log("s4", lb, eg, ed);
    if (wlog.size() >= lb + 3) chk("s4_gap_resume_cycle", wlog[lb+2].cyc, t0 + 8);

    // reset mid-packet, then 0 beats 1 in the first arbitration
    add_pkt(1, 6, 'h60); drive();
    step(); step(); step();
    #2;
    do_reset();
    lb = wlog.size();
    add_pkt(0, 1, 'h70); add_pkt(1, 1, 'h71); drive();
    run("s5", 50);
    eg = '{0, 1}; ed = '{'h70, 'h71};
    chk_log("s5", lb, eg, ed);

    // long packet from 0 while 1 requests
    lb = wlog.size();
    add_pkt(0, 10, 'h80); add_pkt(1, 3, 'h90);
    gap_sched[1] = '{1};
    drive();
    run("s6", 100);
`ifdef ARB_BURST_LIMIT_EN
    eg = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    ed = '{'h80, 'h81, 'h82, 'h83, 'h90, 'h91, 'h92, 'h84, 'h85, 'h86, 'h87, 'h88, 'h89};
`else
    eg = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
    ed = '{'h80, 'h81, 'h82, 'h83, 'h84, 'h85, 'h86, 'h87, 'h88, 'h89, 'h90, 'h91, 'h92};
`endif
    chk_log("s6", lb, eg, ed);

    // randomized traffic with backpressure and source stalls
    for (int r = 0; r < 3; r++) begin
      full_pct = 10 * r + 5;
      gap_pct  = 25 - 8 * r;
      for (int p = 0; p < 16; p++)
        add_pkt($urandom_range(N-1), $urandom_range(9, 1), $urandom_range(255));
      drive();
      run("rand", 4000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axis_byte_arbiter.md
Name: axis_byte_arbiter

Overview:
- Shares the single byte-wide asynchronous-FIFO write port (`o_to_fifo`/`w_req`/`w_full`) between `NUM_SRC` byte-serialised streams.
- Each stream is the byte-level output of one AXIS manager-side serialiser.
- Round-robin, packet-locked arbitration: a granted source keeps the port until it sends a byte with `last`, so packets are never interleaved in the FIFO.
- Sits between the per-channel serialisers and the shared CDC FIFO, in the `m_axis_aclk` domain.

Parameters:
- `NUM_SRC`, 4, number of requesting byte streams (2..16).
- `MAX_BURST`, 16, maximum bytes per grant. Used only with `ARB_BURST_LIMIT_EN`. Range 1..255.

Ports:
- `m_axis_aclk`  in  1  clock.
- `m_axis_reset_n`  in  1  reset, asynchronous, active-low.
- `s_byte_data`  in  `NUM_SRC*8`  byte from source i on bits [i*8 +: 8].
- `s_byte_valid`  in  `NUM_SRC`  source i has a byte.
- `s_byte_last`  in  `NUM_SRC`  byte from source i is the last byte of its packet.
- `s_byte_ready`  out  `NUM_SRC`  byte from source i accepted this cycle when valid.
- `o_to_fifo`  out  8  byte to the async FIFO write data.
- `w_req`  out  1  write strobe to the async FIFO.
- `w_full`  in  1  async FIFO full.
- `o_grant_id`  out  `$clog2(NUM_SRC)`  currently or last granted source index.
- `o_busy`  out  1  a grant is held.

Behaviour:
- Reset (async, active low):
  - State = IDLE.
  - `o_grant_id` = 0; `o_busy` = 0; `s_byte_ready` = 0; `w_req` = 0; `o_to_fifo` = 0.
  - Round-robin pointer `last_grant` = `NUM_SRC`-1, so source 0 has first priority.
  - Burst counter = 0.
- FSM states: IDLE, GRANT.
- IDLE:
  - If any `s_byte_valid` bit is set, select the first valid index searching upward from `last_grant`+1, modulo `NUM_SRC`.
  - Register the selection into `o_grant_id` and `last_grant`, clear the burst counter, go to GRANT.
  - Otherwise stay in IDLE.
  - Arbitration costs exactly one bubble cycle; no byte transfers in IDLE.
- GRANT (g = `o_grant_id`):
  - Combinational outputs:
    - `s_byte_ready[g]` = !`w_full`.
    - All other ready bits = 0.
    - `o_to_fifo` = `s_byte_data[g*8 +: 8]`.
    - `w_req` = `s_byte_valid[g]` && !`w_full`.
  - A transfer is `w_req` = 1: exactly one FIFO write per accepted byte, zero latency source to FIFO.
  - On a transfer with `s_byte_last[g]` = 1: go to IDLE on the next cycle.
  - On a transfer without `last`: stay in GRANT and increment the burst counter.
  - Granted source drops valid mid-packet: grant is held (no time-out), `w_req` = 0.
  - `w_full` asserted: no ready, no `w_req`, grant held, byte held by source; resumes the cycle `w_full` deasserts.
- `o_busy` = (state == GRANT).
- `o_to_fifo` is forced to 0 outside GRANT and during reset.
- New requests arriving during GRANT are not visible until the next IDLE. Simultaneous requests in IDLE are resolved by round-robin only.
- Pointer wrap: after index `NUM_SRC`-1 the search continues from 0.
- A reset asserted mid-packet abandons the grant immediately. The upstream serialiser is reset by the same net.

Optional Feature:
- Macro: `ARB_BURST_LIMIT_EN`.
- Defined:
  - The grant is also released after a transfer that brings the burst counter to `MAX_BURST` bytes, even without `last`.
  - The source re-arbitrates as a normal requester, so packets may interleave at `MAX_BURST` granularity. This bounds latency for other sources.
  - The counter is 8 bits and resets on every new grant.
- Undefined:
  - Only `last` releases a grant.
  - Burst counter logic and `MAX_BURST` are unused.

Test Plan:
- Single source 1 sends 3-byte packet 0xA1,0xA2,0xA3 (`last` on 0xA3) -> one IDLE cycle, then `w_req` on 3 consecutive cycles with those bytes, `o_grant_id`=1, back to IDLE, `o_busy`=0.
- Sources 0,1,2 all request 2-byte packets simultaneously from reset -> grant order 0,1,2; FIFO sees 6 bytes with no interleave; `last_grant`=2.
- Source 3 granted, `w_full` held high 4 cycles mid-packet -> `s_byte_ready`=0 and `w_req`=0 for those 4 cycles, no byte lost or duplicated, transfer resumes with the held byte.
- Source 2 granted, drops valid for 5 cycles mid-packet while source 0 requests -> source 0 never granted until source 2 sends `last`; `w_req`=0 during the gap.
- Reset pulsed while source 1 mid-packet -> all outputs return to reset values asynchronously; after release, source 0 wins the first arbitration when 0 and 1 request together.
- With `ARB_BURST_LIMIT_EN`, `MAX_BURST`=4, source 0 sends 10-byte packet and source 1 requests -> FIFO order is 4 bytes from source 0, then source 1's packet, then 4 bytes from source 0, then the remainder.
